// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the debounce scan controller.
package debounce_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Channel index width; a single channel still needs one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width able to hold 0..val inclusive.
  function automatic int unsigned upto_width(input int unsigned val);
    return (val <= 1) ? 1 : $clog2(val + 1);
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Small synchronous FIFO for debounce events; push while full is only taken with a pop.
module evt_fifo
  import debounce_pkg::*;
#(
  parameter int unsigned W     = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_full
);

  localparam int unsigned PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned OCC_W = upto_width(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [OCC_W-1:0] r_count;
  logic             w_pop;
  logic             w_push;

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == OCC_W'(DEPTH));
  assign o_data  = r_mem[r_rd];
  assign w_pop   = i_pop && o_valid;
  assign w_push  = i_push && (!o_full || w_pop);

  // Storage, pointers and occupancy; pointers wrap naturally at power-of-2 depth.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + PTR_W'(1);
      end
      if (w_pop) r_rd <= r_rd + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Time-multiplexed debouncer: one shared counter datapath scans all channels once per tick.
module debounce_scan_ctrl
  import debounce_pkg::*;
#(
  parameter  int unsigned N_CH         = 4,
  parameter  int unsigned TICK_DIV     = 32000,
  parameter  int unsigned STABLE_TICKS = 5,
  parameter  int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned CH_W         = ch_width(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] indata,
  output logic [N_CH-1:0] stable,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_level,
  output logic            overflow,
  input  logic            clr_overflow,
  output logic            busy
);

  localparam int unsigned CNT_W   = upto_width(STABLE_TICKS);
  localparam int unsigned PRESC_W = upto_width(TICK_DIV - 1);

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(STABLE_TICKS - 1);
  localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [CH_W-1:0]    IDX_LAST  = CH_W'(N_CH - 1);

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            level;
  } evt_t;

  if (TICK_DIV <= N_CH + 1) begin : g_bad_tick_div
    $error("TICK_DIV must exceed N_CH+1 so a scan finishes before the next tick");
  end

  state_t              r_state;
  logic [CH_W-1:0]     r_idx;
  logic                r_busy;
  logic [N_CH-1:0]     r_stable;
  logic [CNT_W-1:0]    r_cnt [N_CH];
  logic [N_CH-1:0]     r_sync1;
  logic [N_CH-1:0]     r_sync2;
  logic [PRESC_W-1:0]  r_presc;
  logic                r_overflow;

  logic                w_tick;
  logic                w_s;
  logic                w_differs;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  evt_t                w_evt_in;
  evt_t                w_evt_out;

  assign w_tick    = (r_presc == TICK_LAST);
  assign w_s       = r_sync2[r_idx];
  assign w_differs = (w_s != r_stable[r_idx]);
  assign w_accept  = w_differs && (r_cnt[r_idx] == CNT_LAST);
  assign w_push    = (r_state == SCAN) && w_accept;
  assign w_pop     = evt_valid && evt_ready;
  assign w_evt_in  = '{ch: r_idx, level: w_s};

  // Two-flop synchronizer for the raw asynchronous inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= indata;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running sample-tick prescaler.
  always_ff @(posedge clk) begin
    if (!reset) r_presc <= '0;
    else        r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
  end

  // Scan FSM: one channel per cycle compares its sample and advances its counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_stable <= '0;
      for (int i = 0; i < int'(N_CH); i++) r_cnt[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_state <= SCAN;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (!w_differs) begin
            r_cnt[r_idx] <= '0;
          end else if (w_accept) begin
            r_stable[r_idx] <= w_s;
            r_cnt[r_idx]    <= '0;
          end else begin
            r_cnt[r_idx] <= r_cnt[r_idx] + CNT_W'(1);
          end
          if (r_idx == IDX_LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_idx <= r_idx + CH_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky drop flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset)                            r_overflow <= 1'b0;
    else if (w_push && w_full && !w_pop)   r_overflow <= 1'b1;
    else if (clr_overflow)                 r_overflow <= 1'b0;
  end

  evt_fifo #(
    .W     ($bits(evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_evt_in),
    .i_pop   (evt_ready),
    .o_data  (w_evt_out),
    .o_valid (evt_valid),
    .o_full  (w_full)
  );

  assign stable    = r_stable;
  assign busy      = r_busy;
  assign overflow  = r_overflow;
  assign evt_ch    = w_evt_out.ch;
  assign evt_level = w_evt_out.level;

endmodule

// File: doc/debounce_scan_ctrl.md
Name: debounce_scan_ctrl

Overview:
Time-multiplexed debounce controller for N_CH raw button/contact inputs. One shared sample-tick prescaler and one scan FSM sequence a single compare/count datapath across all channels: one channel per clock, once per tick. Outputs per-channel debounced levels, plus a buffered valid/ready event stream (channel id, new level) for a downstream CPU/UART reporter.

Parameters:
N_CH, 4, number of input channels (>=1)
TICK_DIV, 32000, clk cycles per sample tick (1 ms at 32 MHz); must be > N_CH+1 (elaboration assert)
STABLE_TICKS, 5, consecutive differing samples required to accept a new level (>=1)
FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
indata  in  N_CH  raw asynchronous inputs
stable  out  N_CH  debounced levels
evt_valid  out  1  event FIFO non-empty
evt_ready  in  1  consumer accepts head event
evt_ch  out  CH_W=max(1,$clog2(N_CH))  channel id of head event
evt_level  out  1  new debounced level of head event
overflow  out  1  sticky: an event was dropped
clr_overflow  in  1  one-cycle clear of overflow
busy  out  1  high while FSM in SCAN

Behaviour:
- Reset: sampled at posedge with reset==0. Clears stable, sync flops, all counters, prescaler, idx, and FIFO pointers/count. overflow=0, FSM=IDLE. Hence evt_valid=0, busy=0, evt_ch=0, evt_level=0. Applies mid-scan and mid-handshake; pending events are discarded.
- Synchronizer: each indata bit passes through 2 flops (sync_q) before use.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for one cycle when count==TICK_DIV-1. Free-running, independent of FSM.
- FSM IDLE: on tick -> SCAN, idx=0.
- FSM SCAN: processes channel idx each cycle.
  - s=sync_q[idx].
  - If s==stable[idx]: cnt[idx]<=0.
  - Else if cnt[idx]+1==STABLE_TICKS: stable[idx]<=s, cnt[idx]<=0, push event {idx,s}.
  - Else: cnt[idx]<=cnt[idx]+1.
  - idx==N_CH-1 -> IDLE. Otherwise idx+1.
  - busy=1 for exactly N_CH cycles per tick.
- Counter width: $clog2(STABLE_TICKS+1); cnt never exceeds STABLE_TICKS-1.
- Timing: stable[idx] and the FIFO entry update on the same edge. evt_valid rises that edge if the FIFO was empty (zero added latency). The acceptance threshold is exactly STABLE_TICKS consecutive tick samples differing from stable; any matching sample resets the count.
- FIFO handshake: pop when evt_valid && evt_ready. evt_ch/evt_level are held constant while evt_valid && !evt_ready.
- Push to full FIFO with simultaneous pop: accepted, count unchanged.
- Push to full FIFO without pop: event dropped, overflow<=1, stable still updated.
- Pop with push on empty FIFO cannot occur (evt_valid=0).
- overflow: cleared by clr_overflow. Set wins if clr_overflow and a new drop occur in the same cycle.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter width $clog2(FIFO_DEPTH+1).

Decomposition:
- Package debounce_pkg: function clog2-based width helpers; typedef evt_t struct {ch, level} parameterised via localparam CH_W in the module; FSM enum state_t {IDLE, SCAN}.
- One natural sub-module: evt_fifo (sync FIFO, push/pop/full/empty, same reset), instantiated once. Synchronizer and prescaler are inline.

Test Plan:
All scenarios use N_CH=4, TICK_DIV=8, STABLE_TICKS=3, FIFO_DEPTH=2, clk 32 MHz.
1. Reset: hold reset=0 for 5 cycles with indata=4'hF -> stable=0, evt_valid=0, overflow=0, busy=0; busy pulses 4 cycles every 8 after release.
2. Hold indata[1]=1 -> stable[1] rises on the 3rd tick scan, at the idx=1 cycle. Single event ch=1, level=1, with evt_ready=1 popped next cycle. Release to 0 -> event ch=1, level=0 after 3 ticks.
3. Glitch: indata[0]=1 for 2 ticks, then 0 -> stable[0] stays 0, no event, cnt[0] returns 0.
4. Backpressure: evt_ready=0, raise indata[0], indata[2], indata[3] together -> stable=4'b1101. FIFO holds {0,1},{2,1}; overflow=1. Then evt_ready=1 -> exactly those 2 events in order; clr_overflow -> overflow=0.
5. Full FIFO with evt_ready=1 on the same cycle a new channel flips -> no drop, overflow stays 0, all events delivered in order.
6. Drive reset=0 during SCAN (idx=2) with 1 event queued -> next cycle busy=0, evt_valid=0, stable=0; normal operation resumes after release.
